// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and the blocks that consume its key codes.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_ONE,
    SCAN_MULTI
  } scan_e;

  // Key index (row*4 + col) to printed legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
  localparam logic [63:0] KEY_LEGEND = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_legend(input logic [3:0] idx);
    return KEY_LEGEND[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low row lines; resets to the idle (all released) level.
module keypad_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_in,
  output logic [3:0] q_out
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: column strobing, per-scan press accumulation and press/release debounce FSM.
//   state       | meaning
//   ST_IDLE     | no key accepted, waiting for a single-key scan
//   ST_DEBOUNCE | candidate key seen, counting agreeing scans
//   ST_PRESSED  | key accepted, waiting for an empty scan
//   ST_RELEASE  | empty scans seen, counting toward release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int              TW        = $clog2(SCAN_TICKS);
  localparam int              MW        = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [MW-1:0]   DEB_N     = MW'(DEBOUNCE_SCANS);
  localparam bit              DEB_ONE   = (DEBOUNCE_SCANS == 1);

  logic [NUM_ROWS-1:0] row_sync;
  logic [TW-1:0]       tick_q, tick_d;
  logic [1:0]          col_q, col_d;
  logic                tick_last;
  logic [1:0]          cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  scan_e               scan_q, scan_d;
  logic [3:0]          scan_idx_q, scan_idx_d;
  logic                scan_vld_q, scan_vld_d;
  state_e              state_q, state_d;
  logic [3:0]          cand_q, cand_d;
  logic [MW-1:0]       match_q, match_d;
  logic [MW-1:0]       match_inc;
  logic                match_done;
  logic                is_one;
  logic                accept;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;

  keypad_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (row_in),
    .q_out (row_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      scan_q      <= SCAN_NONE;
      scan_idx_q  <= '0;
      scan_vld_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      match_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      scan_q      <= scan_d;
      scan_idx_q  <= scan_idx_d;
      scan_vld_q  <= scan_vld_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    tick_last = (tick_q == TICK_LAST);
    tick_d    = tick_last ? '0 : tick_q + 1'b1;
    col_d     = tick_last ? col_q + 2'd1 : col_q;
  end

  // Rows are sampled once per column; column 0 restarts the accumulator, column 3 closes the scan.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    scan_d     = scan_q;
    scan_idx_d = scan_idx_q;
    scan_vld_d = 1'b0;
    if (tick_last) begin
      if (col_q == 2'd0) begin
        cnt_d = '0;
        idx_d = '0;
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!row_sync[r]) begin
          if (cnt_d != 2'd2) cnt_d = cnt_d + 2'd1;
          idx_d = {2'(r), col_q};
        end
      end
      if (col_q == 2'd3) begin
        scan_vld_d = 1'b1;
        scan_idx_d = idx_d;
        case (cnt_d)
          2'd0:    scan_d = SCAN_NONE;
          2'd1:    scan_d = SCAN_ONE;
          default: scan_d = SCAN_MULTI;
        endcase
      end
    end
  end

  assign match_inc  = match_q + MW'(1);
  assign match_done = (match_inc == DEB_N);
  // Ghosted (multi-key) scans count as empty.
  assign is_one     = (scan_q == SCAN_ONE);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    if (scan_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (is_one) begin
            cand_d  = scan_idx_q;
            match_d = MW'(1);
            state_d = DEB_ONE ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!is_one) begin
            match_d = '0;
            state_d = ST_IDLE;
          end else if (scan_idx_q == cand_q) begin
            match_d = match_inc;
            if (match_done) state_d = ST_PRESSED;
          end else begin
            cand_d  = scan_idx_q;
            match_d = MW'(1);
          end
        end
        ST_PRESSED: begin
          if (!is_one) begin
            match_d = MW'(1);
            state_d = DEB_ONE ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (is_one) begin
            state_d = ST_PRESSED;
          end else if (match_done) begin
            match_d = '0;
            state_d = ST_IDLE;
          end else begin
            match_d = match_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    accept      = (state_d == ST_PRESSED) &&
                  ((state_q == ST_IDLE) || (state_q == ST_DEBOUNCE));
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    col_out     = ~(4'b0001 << col_q);
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: matrix model on the pins, scoreboard of expected key codes.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  mon_exp;
  logic [3:0]  exp_q[$];

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  // Scoreboard consumer: every key_valid pops one expected code.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ($countones(~col_out) != 1) begin
        bad++;
        $display("FAIL col_onehot: col_out=%b, required exactly one low bit", col_out);
      end
      if (key_valid) begin
        valid_cnt++;
        total++;
        if (prev_valid) begin
          bad++;
          $display("FAIL valid_back_to_back: key_valid high on two consecutive cycles");
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: key_valid with code=%0d, required no pulse", key_code);
        end else begin
          mon_exp = exp_q.pop_front();
          if (key_code !== mon_exp) begin
            bad++;
            $display("FAIL sb_code: key_code=%0d required %0d", key_code, mon_exp);
          end
          total++;
          if (key_held !== 1'b1) begin
            bad++;
            $display("FAIL sb_held: key_held=%b required 1 with key_valid", key_held);
          end
        end
      end
    end
    prev_valid = key_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic align_col(input logic [3:0] target);
    logic [3:0] prev;
    for (int i = 0; i < 40; i++) begin
      prev = col_out;
      step(1);
      if (prev != target && col_out == target) return;
    end
  endtask

  task automatic wait_valid(input int bound, output int lat, output bit ok);
    int start;
    start = valid_cnt;
    lat = 0;
    ok = 1'b0;
    while (!ok && lat < bound) begin
      step(1);
      lat++;
      if (valid_cnt != start) ok = 1'b1;
    end
  endtask

  task automatic wait_held_low(input int bound, output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    while (!ok && lat < bound) begin
      step(1);
      lat++;
      if (key_held == 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst_n = 1'b0;
    keys = '0;
    step(5);
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL rst_col: col_out=%b required 1110", col_out); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL rst_code: key_code=%0d required 0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: key_valid=%b required 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst_held: key_held=%b required 0", key_held); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      e = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (col_out !== e) begin
        bad++;
        $display("FAIL col_seq[%0d]: col_out=%b required %b", k, col_out, e);
      end
    end
  endtask

  task automatic release_all(input string name);
    int lat;
    bit ok;
    keys = '0;
    wait_held_low(100, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_release: key_held=%b after 100 cycles, required 0", name, key_held); end
  endtask

  task automatic test_clean_press();
    int v0, lat;
    bit ok;
    align_col(4'b1101);
    v0 = valid_cnt;
    exp_q.push_back(4'd9);
    keys[9] = 1'b1;
    wait_valid(80, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clean_timeout: no key_valid in 80 cycles, required one"); end
    total++;
    if (lat < 35 || lat > 51) begin bad++; $display("FAIL clean_latency: latency=%0d required 35..51", lat); end
    step(200);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL clean_count: pulses=%0d required 1", valid_cnt - v0); end
    total++; if (key_code !== 4'd9) begin bad++; $display("FAIL clean_code: key_code=%0d required 9", key_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held: key_held=%b required 1", key_held); end
    release_all("clean");
  endtask

  task automatic test_bounce();
    int v0, lat;
    bit ok;
    align_col(4'b1110);
    step(3);
    v0 = valid_cnt;
    for (int i = 0; i < 10; i++) begin
      keys[3] = (i % 2 == 0);
      step(10);
    end
    total++;
    if (valid_cnt != v0) begin bad++; $display("FAIL bounce_quiet: pulses=%0d during bounce required 0", valid_cnt - v0); end
    exp_q.push_back(4'd3);
    keys[3] = 1'b1;
    wait_valid(80, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bounce_timeout: no key_valid in 80 cycles after hold, required one"); end
    total++;
    if (key_code !== 4'd3) begin bad++; $display("FAIL bounce_code: key_code=%0d required 3", key_code); end
    release_all("bounce");
  endtask

  task automatic test_two_keys();
    int v0, lat;
    bit ok;
    v0 = valid_cnt;
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    step(100);
    total++;
    if (valid_cnt != v0) begin bad++; $display("FAIL ghost_quiet: pulses=%0d with two keys required 0", valid_cnt - v0); end
    exp_q.push_back(4'd4);
    keys[6] = 1'b0;
    wait_valid(80, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ghost_timeout: no key_valid in 80 cycles, required one"); end
    total++;
    if (key_code !== 4'd4) begin bad++; $display("FAIL ghost_code: key_code=%0d required 4", key_code); end
    release_all("ghost");
  endtask

  task automatic test_switch();
    int v0, lat;
    bit ok;
    exp_q.push_back(4'd15);
    keys[15] = 1'b1;
    wait_valid(80, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL switch_timeout: no key_valid in 80 cycles, required one"); end
    v0 = valid_cnt;
    keys[15] = 1'b0;
    keys[0]  = 1'b1;
    step(100);
    total++; if (valid_cnt != v0) begin bad++; $display("FAIL switch_quiet: pulses=%0d after switch required 0", valid_cnt - v0); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL switch_held: key_held=%b required 1", key_held); end
    total++; if (key_code !== 4'd15) begin bad++; $display("FAIL switch_code: key_code=%0d required 15", key_code); end
    keys[0] = 1'b0;
    wait_held_low(90, lat, ok);
    total++;
    if (!ok || lat < 30 || lat > 70) begin
      bad++;
      $display("FAIL switch_release: held fell=%0d after %0d cycles, required within 30..70", ok, lat);
    end
  endtask

  task automatic test_reset_mid();
    int v0, lat;
    bit ok;
    align_col(4'b1101);
    v0 = valid_cnt;
    keys[5] = 1'b1;
    step(30);
    total++;
    if (valid_cnt != v0) begin bad++; $display("FAIL midrst_early: pulses=%0d before reset required 0", valid_cnt - v0); end
    rst_n = 1'b0;
    step(1);
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL midrst_col: col_out=%b required 1110", col_out); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL midrst_code: key_code=%0d required 0", key_code); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL midrst_held: key_held=%b required 0", key_held); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: key_valid=%b required 0", key_valid); end
    step(3);
    exp_q.push_back(4'd5);
    rst_n = 1'b1;
    wait_valid(80, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_timeout: no key_valid in 80 cycles after reset, required one"); end
    total++;
    if (key_code !== 4'd5) begin bad++; $display("FAIL midrst_code_after: key_code=%0d required 5", key_code); end
    release_all("midrst");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_switch();
    test_reset_mid();
    step(20);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected codes never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
